// File: rtl/lives_ctrl.sv
// Player lives / invulnerability controller for the heart overlay.
// Tracks lives, a post-hit invulnerability frame timer and game-over, with registered outputs.
module lives_ctrl #(
  parameter int MAX_LIVES     = 2,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_LOG2    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       life_up,
  input  logic       restart,
  output logic [1:0] lives,
  output logic       hearts_visible,
  output logic       invuln,
  output logic       game_over,
  output logic       life_lost
);

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_INVULN    = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(MAX_LIVES);
  localparam logic [7:0] TMR_LOAD   = 8'(INVULN_FRAMES);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_tmr;
  logic [7:0] w_tmr_nxt;
  logic [1:0] r_lives;
  logic [1:0] w_lives_nxt;
  logic       w_life_lost_nxt;
  logic       w_hearts_nxt;
  logic       r_life_lost;
  logic       r_hearts_visible;
  logic       r_invuln;
  logic       r_game_over;

  // State, counters and output flags, all updated from the computed next values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_ALIVE;
      r_tmr            <= 8'd0;
      r_lives          <= LIVES_INIT;
      r_life_lost      <= 1'b0;
      r_hearts_visible <= 1'b1;
      r_invuln         <= 1'b0;
      r_game_over      <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_tmr            <= w_tmr_nxt;
      r_lives          <= w_lives_nxt;
      r_life_lost      <= w_life_lost_nxt;
      r_hearts_visible <= w_hearts_nxt;
      r_invuln         <= (w_state_nxt == ST_INVULN);
      r_game_over      <= (w_state_nxt == ST_GAME_OVER);
    end
  end

  // Next-state logic: restart beats hit, an accepted hit swallows life_up.
  always_comb begin
    w_state_nxt     = r_state;
    w_tmr_nxt       = r_tmr;
    w_lives_nxt     = r_lives;
    w_life_lost_nxt = 1'b0;
    if (restart) begin
      w_state_nxt = ST_ALIVE;
      w_tmr_nxt   = 8'd0;
      w_lives_nxt = LIVES_INIT;
    end else begin
      case (r_state)
        ST_ALIVE: begin
          if (hit) begin
            w_life_lost_nxt = 1'b1;
            if (r_lives >= 2'd2) begin
              w_lives_nxt = r_lives - 2'd1;
              w_tmr_nxt   = TMR_LOAD;
              w_state_nxt = ST_INVULN;
            end else begin
              w_lives_nxt = 2'd0;
              w_tmr_nxt   = 8'd0;
              w_state_nxt = ST_GAME_OVER;
            end
          end else if (life_up && (r_lives < LIVES_INIT)) begin
            w_lives_nxt = r_lives + 2'd1;
          end else begin
            w_lives_nxt = r_lives;
          end
        end
        ST_INVULN: begin
          if (life_up && (r_lives < LIVES_INIT)) begin
            w_lives_nxt = r_lives + 2'd1;
          end else begin
            w_lives_nxt = r_lives;
          end
          // A zero timer here can only come from corruption; treat it as expiry.
          if (frame_tick && !hit) begin
            if (r_tmr <= 8'd1) begin
              w_tmr_nxt   = 8'd0;
              w_state_nxt = ST_ALIVE;
            end else begin
              w_tmr_nxt = r_tmr - 8'd1;
            end
          end else begin
            w_tmr_nxt = r_tmr;
          end
        end
        ST_GAME_OVER: begin
          w_state_nxt = ST_GAME_OVER;
        end
        default: begin
          w_state_nxt = ST_ALIVE;
          w_tmr_nxt   = 8'd0;
          w_lives_nxt = LIVES_INIT;
        end
      endcase
    end
    if (w_state_nxt == ST_INVULN) begin
      w_hearts_nxt = ~w_tmr_nxt[BLINK_LOG2];
    end else begin
      w_hearts_nxt = 1'b1;
    end
  end

  assign lives          = r_lives;
  assign hearts_visible = r_hearts_visible;
  assign invuln         = r_invuln;
  assign game_over      = r_game_over;
  assign life_lost      = r_life_lost;

endmodule

// File: tb/tb_lives_ctrl.sv
// Directed self-checking bench for lives_ctrl with default parameters.
module tb_lives_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       hit;
  logic       life_up;
  logic       restart;
  logic [1:0] lives;
  logic       hearts_visible;
  logic       invuln;
  logic       game_over;
  logic       life_lost;

  int total;
  int bad;

  lives_ctrl #(.MAX_LIVES(2), .INVULN_FRAMES(120), .BLINK_LOG2(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .hit            (hit),
    .life_up        (life_up),
    .restart        (restart),
    .lives          (lives),
    .hearts_visible (hearts_visible),
    .invuln         (invuln),
    .game_over      (game_over),
    .life_lost      (life_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 ns after the edge.
  task automatic step(input logic h, input logic lu, input logic ft, input logic rs);
    hit        = h;
    life_up    = lu;
    frame_tick = ft;
    restart    = rs;
    @(posedge clk);
    #1;
    hit        = 1'b0;
    life_up    = 1'b0;
    frame_tick = 1'b0;
    restart    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if ({lives, hearts_visible, invuln, game_over, life_lost} !== {2'd2, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got lives=%0d hv=%0b inv=%0b go=%0b ll=%0b, want 2 1 0 0 0",
               lives, hearts_visible, invuln, game_over, life_lost);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b0, (i % 3) == 0, 1'b0);
      total++;
      if ({lives, hearts_visible, invuln, game_over, life_lost} !== {2'd2, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL idle_cycle %0d: got lives=%0d hv=%0b inv=%0b go=%0b ll=%0b, want 2 1 0 0 0",
                 i, lives, hearts_visible, invuln, game_over, life_lost);
      end
    end
  endtask

  task automatic test_hit_invuln();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if ({lives, invuln, life_lost, hearts_visible, game_over} !== {2'd1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL first_hit: got lives=%0d inv=%0b ll=%0b hv=%0b go=%0b, want 1 1 1 0 0",
               lives, invuln, life_lost, hearts_visible, game_over);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (life_lost !== 1'b0) begin
      bad++;
      $display("FAIL life_lost_one_cycle: got %0b want 0", life_lost);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if ({lives, invuln, life_lost} !== {2'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL hit_in_invuln: got lives=%0d inv=%0b ll=%0b, want 1 1 0", lives, invuln, life_lost);
    end
    // Timer starts at 120; after k ticks it is 120-k and hearts show NOT bit 3.
    for (int k = 1; k <= 120; k++) begin
      int   t;
      logic exp_hv;
      logic exp_inv;
      step(1'b0, 1'b0, 1'b1, 1'b0);
      t       = 120 - k;
      exp_inv = (k < 120);
      exp_hv  = exp_inv ? ~t[3] : 1'b1;
      total++;
      if ({invuln, hearts_visible, lives} !== {exp_inv, exp_hv, 2'd1}) begin
        bad++;
        $display("FAIL blink_tick %0d: got inv=%0b hv=%0b lives=%0d, want %0b %0b 1",
                 k, invuln, hearts_visible, lives, exp_inv, exp_hv);
      end
    end
  endtask

  task automatic test_game_over();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if ({lives, game_over, invuln, life_lost, hearts_visible} !== {2'd0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL last_hit: got lives=%0d go=%0b inv=%0b ll=%0b hv=%0b, want 0 1 0 1 1",
               lives, game_over, invuln, life_lost, hearts_visible);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if ({lives, game_over, invuln, life_lost} !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL game_over_sticky: got lives=%0d go=%0b inv=%0b ll=%0b, want 0 1 0 0",
               lives, game_over, invuln, life_lost);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if ({lives, game_over, invuln, hearts_visible} !== {2'd2, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL restart_from_go: got lives=%0d go=%0b inv=%0b hv=%0b, want 2 0 0 1",
               lives, game_over, invuln, hearts_visible);
    end
  endtask

  task automatic test_life_up();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({lives, invuln} !== {2'd2, 1'b0}) begin
      bad++;
      $display("FAIL life_up_saturate: got lives=%0d inv=%0b, want 2 0", lives, invuln);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if ({lives, invuln, life_lost} !== {2'd1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL hit_plus_life_up: got lives=%0d inv=%0b ll=%0b, want 1 1 1", lives, invuln, life_lost);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({lives, invuln, hearts_visible} !== {2'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL life_up_in_invuln: got lives=%0d inv=%0b hv=%0b, want 2 1 0", lives, invuln, hearts_visible);
    end
    // Timer must still be 120: 119 ticks stay invulnerable, the 120th ends it.
    for (int k = 0; k < 119; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (invuln !== 1'b1) begin
      bad++;
      $display("FAIL tmr_unchanged_119: got inv=%0b want 1", invuln);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if ({invuln, lives, hearts_visible} !== {1'b0, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL tmr_unchanged_120: got inv=%0b lives=%0d hv=%0b, want 0 2 1", invuln, lives, hearts_visible);
    end
  endtask

  task automatic test_restart_and_rst();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    total++;
    if ({lives, invuln, life_lost, game_over} !== {2'd2, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL restart_beats_hit: got lives=%0d inv=%0b ll=%0b go=%0b, want 2 0 0 0",
               lives, invuln, life_lost, game_over);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #2;
    total++;
    if ({lives, invuln, game_over, life_lost, hearts_visible} !== {2'd2, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL async_rst_mid_invuln: got lives=%0d inv=%0b go=%0b ll=%0b hv=%0b, want 2 0 0 0 1",
               lives, invuln, game_over, life_lost, hearts_visible);
    end
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if ({lives, invuln, life_lost} !== {2'd1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL hit_after_rst: got lives=%0d inv=%0b ll=%0b, want 1 1 1", lives, invuln, life_lost);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    hit        = 1'b0;
    life_up    = 1'b0;
    frame_tick = 1'b0;
    restart    = 1'b0;
    test_reset();
    test_hit_invuln();
    test_game_over();
    test_life_up();
    test_restart_and_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lives_ctrl.md
LIVES_CTRL -- requirements
Module: lives_ctrl

Interface
REQ-001 SHALL have parameter: MAX_LIVES, default 2, lives count loaded at reset/restart (legal 1..3).
REQ-002 SHALL have parameter: INVULN_FRAMES, default 120, invulnerability length in frames after a survived hit (legal 1..255).
REQ-003 SHALL have parameter: BLINK_LOG2, default 3, bit of the invulnerability timer that drives heart blinking (legal 0..7).
REQ-004 SHALL have port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-007 SHALL have port: hit  input  1  one-cycle pulse, player took damage.
REQ-008 SHALL have port: life_up  input  1  one-cycle pulse, player collected an extra life.
REQ-009 SHALL have port: restart  input  1  one-cycle pulse, start a new game.
REQ-010 SHALL have port: lives  output  2  current life count; feeds the heart overlay.
REQ-011 SHALL have port: hearts_visible  output  1  gate for the heart overlay; 0 blanks hearts for blinking.
REQ-012 SHALL have port: invuln  output  1  high while in INVULN state.
REQ-013 SHALL have port: game_over  output  1  high while in GAME_OVER state.
REQ-014 SHALL have port: life_lost  output  1  one-cycle pulse when a hit decrements lives.

Function
REQ-015 SHALL implement FSM with states ALIVE, INVULN, GAME_OVER; all outputs registered, reflecting an input event on the clock edge after it is sampled (1-cycle latency).
REQ-016 SHALL hold an 8-bit invulnerability timer (tmr) and 2-bit lives register.
REQ-017 SHALL give priority per cycle: restart > hit > life_up > frame_tick timer decrement.
REQ-018 restart in any state SHALL set lives=MAX_LIVES, tmr=0, state=ALIVE, life_lost=0.
REQ-019 hit in ALIVE with lives>=2 SHALL decrement lives, load tmr=INVULN_FRAMES, enter INVULN, pulse life_lost.
REQ-020 hit in ALIVE with lives==1 SHALL set lives=0, enter GAME_OVER, pulse life_lost, leave tmr=0.
REQ-021 hit in INVULN or GAME_OVER SHALL be ignored (no change, no life_lost).
REQ-022 life_up in ALIVE or INVULN without hit/restart SHALL increment lives, saturating at MAX_LIVES; it SHALL not alter state or tmr.
REQ-023 life_up coincident with an accepted hit SHALL be dropped; life_up in GAME_OVER SHALL be ignored.
REQ-024 In INVULN, frame_tick without hit/restart SHALL decrement tmr; when tmr is 1 and frame_tick arrives, tmr becomes 0 and state returns to ALIVE on that edge.
REQ-025 frame_tick SHALL not affect tmr outside INVULN.
REQ-026 hearts_visible SHALL be 1 in ALIVE and GAME_OVER, and equal to NOT tmr[BLINK_LOG2] in INVULN (computed from registered values).
REQ-027 life_lost SHALL be high for exactly one cycle per accepted hit and 0 otherwise.
REQ-028 lives SHALL never exceed MAX_LIVES nor wrap below 0.

Reset
REQ-029 While rst=1, asynchronously: lives=MAX_LIVES, tmr=0, state=ALIVE, invuln=0, game_over=0, life_lost=0, hearts_visible=1.
REQ-030 rst asserted mid-INVULN SHALL abort the timer immediately; first edge after release behaves as ALIVE.

Verification
REQ-031 Reset release, no events -> lives=2, hearts_visible=1, invuln=0, game_over=0 for 1000 cycles.
REQ-032 hit at lives=2 -> next edge lives=1, invuln=1, life_lost one cycle; second hit during INVULN -> lives stays 1; after 120 frame_ticks -> invuln=0, state ALIVE.
REQ-033 INVULN with BLINK_LOG2=3 -> hearts_visible toggles every 8 frame_ticks, matching NOT tmr[3].
REQ-034 lives=1, hit -> lives=0, game_over=1; then hit, life_up, frame_tick -> no change; restart -> lives=2, game_over=0.
REQ-035 lives=2, life_up -> stays 2; lives=1 in INVULN, life_up -> 2 with tmr unchanged; hit+life_up same cycle at lives=2 -> lives=1, INVULN.
REQ-036 restart+hit same cycle in INVULN -> lives=2, ALIVE, no life_lost; rst pulse mid-INVULN -> outputs at reset values immediately.
